// File: rtl/hbs_pkg.sv
// Shared types, constants and elaboration helpers for the pipelined high-bit search.
// Optional low-bit search mode is enabled with the HBS_LOW_BIT_EN macro.
package hbs_pkg;

  localparam logic HBS_MODE_HIGH = 1'b0;
  localparam logic HBS_MODE_LOW  = 1'b1;

  // Widest index any supported configuration carries (64K-bit words).
  localparam int unsigned HBS_MAX_IDX_WIDTH = 16;

  function automatic int unsigned hbs_clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

  // A node produced after `level` merges locates its bit within 2**level leaves.
  function automatic int unsigned hbs_idx_width(input int unsigned level);
    return level;
  endfunction

  function automatic int unsigned hbs_node_width(input int unsigned level);
    return 1 + hbs_idx_width(level);
  endfunction

  // Widest view of a tree node; per-level storage uses hbs_node_width(level) bits.
  typedef struct packed {
    logic                         found;
    logic [HBS_MAX_IDX_WIDTH-1:0] idx;
  } hbs_node_t;

endpackage

// File: rtl/hbs_merge_node.sv
// Combinational merge of two adjacent search-tree nodes into their parent.
// With HBS_LOW_BIT_EN defined a per-word mode input selects lowest-set-bit priority.
module hbs_merge_node
  import hbs_pkg::*;
#(
  parameter int unsigned ChildIdxWidth = 0,
  localparam int unsigned PortWidth = (ChildIdxWidth == 0) ? 1 : ChildIdxWidth
) (
  input  logic                   lo_found_i,
  input  logic [PortWidth-1:0]   lo_idx_i,
  input  logic                   hi_found_i,
  input  logic [PortWidth-1:0]   hi_idx_i,
`ifdef HBS_LOW_BIT_EN
  input  logic                   mode_i,
`endif
  output logic                   found_o,
  output logic [ChildIdxWidth:0] idx_o
);

  logic take_hi;

`ifdef HBS_LOW_BIT_EN
  // Low mode only picks the high half when the low half is empty, so a zero word stays at 0.
  assign take_hi = (mode_i == HBS_MODE_LOW) ? (hi_found_i & ~lo_found_i) : hi_found_i;
`else
  assign take_hi = hi_found_i;
`endif

  assign found_o = lo_found_i | hi_found_i;

  if (ChildIdxWidth == 0) begin : g_leaf
    // Leaves carry no index bits; the one-bit dummy index ports are intentionally ignored.
    logic unused_idx;
    assign unused_idx = ^{lo_idx_i, hi_idx_i};
    assign idx_o      = take_hi;
  end else begin : g_inner
    assign idx_o = take_hi ? {1'b1, hi_idx_i} : {1'b0, lo_idx_i};
  end

endmodule

// File: rtl/high_bit_search_pipe.sv
// Streaming most-significant-set-bit search: log2-depth merge tree, one register per level,
// bubble-collapsing valid/ready flow control. HBS_LOW_BIT_EN adds a per-word in_mode port.
module high_bit_search_pipe
  import hbs_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = 8,
  parameter int unsigned TAG_WIDTH   = 4,
  localparam int unsigned IDX_WIDTH  = hbs_clog2(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic [TAG_WIDTH-1:0]   in_tag,
`ifdef HBS_LOW_BIT_EN
  input  logic                   in_mode,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_WIDTH-1:0]   out_index,
  output logic                   out_found,
  output logic [TAG_WIDTH-1:0]   out_tag
);

  localparam int unsigned LEVELS    = IDX_WIDTH;
  localparam int unsigned PAD_WIDTH = 1 << IDX_WIDTH;

  logic [LEVELS-1:0]    stage_valid_q, stage_valid_d;
  logic [LEVELS-1:0]    stage_load;
  logic [LEVELS-1:0]    upstream_valid;
  logic [PAD_WIDTH-1:0] pad_data;

  // Padding sits above the real MSB and is zero, so it can never win the search.
  assign pad_data = PAD_WIDTH'(in_data);

  // Load chain runs from the output back to the input, so in_ready sees out_ready directly.
  always_comb begin
    stage_load = '0;
    stage_load[LEVELS-1] = out_ready | ~stage_valid_q[LEVELS-1];
    for (int k = int'(LEVELS) - 2; k >= 0; k--) begin
      stage_load[k] = ~stage_valid_q[k] | stage_load[k+1];
    end
  end

  assign upstream_valid = LEVELS'({stage_valid_q, in_valid});
  assign stage_valid_d  = (stage_load & upstream_valid) | (~stage_load & stage_valid_q);
  assign in_ready       = stage_load[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_q <= '0;
    end else begin
      stage_valid_q <= stage_valid_d;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int unsigned Nodes      = PAD_WIDTH >> (l + 1);
    localparam int unsigned ChildW     = hbs_idx_width(l);
    localparam int unsigned ChildPortW = (ChildW == 0) ? 1 : ChildW;
    localparam int unsigned NodeW      = hbs_idx_width(l + 1);

    logic [2*Nodes-1:0]            child_found;
    logic [2*Nodes*ChildPortW-1:0] child_idx;
    logic [TAG_WIDTH-1:0]          child_tag;
    logic [Nodes-1:0]              found_d, found_q;
    logic [Nodes*NodeW-1:0]        idx_d, idx_q;
    logic [TAG_WIDTH-1:0]          tag_q;
    logic                          load_data;
`ifdef HBS_LOW_BIT_EN
    logic                          child_mode, mode_q;
`endif

    if (l == 0) begin : g_src_input
      assign child_found = pad_data;
      assign child_idx   = '0;
      assign child_tag   = in_tag;
`ifdef HBS_LOW_BIT_EN
      assign child_mode  = in_mode;
`endif
    end else begin : g_src_stage
      assign child_found = g_level[l-1].found_q;
      assign child_idx   = g_level[l-1].idx_q;
      assign child_tag   = g_level[l-1].tag_q;
`ifdef HBS_LOW_BIT_EN
      assign child_mode  = g_level[l-1].mode_q;
`endif
    end

    for (genvar n = 0; n < Nodes; n++) begin : g_node
      hbs_merge_node #(
        .ChildIdxWidth(ChildW)
      ) u_merge (
        .lo_found_i(child_found[2*n]),
        .lo_idx_i  (child_idx[2*n*ChildPortW +: ChildPortW]),
        .hi_found_i(child_found[2*n+1]),
        .hi_idx_i  (child_idx[(2*n+1)*ChildPortW +: ChildPortW]),
`ifdef HBS_LOW_BIT_EN
        .mode_i    (child_mode),
`endif
        .found_o   (found_d[n]),
        .idx_o     (idx_d[n*NodeW +: NodeW])
      );
    end

    // Bubbles advance only the valid bit; payload registers keep their last word.
    assign load_data = stage_load[l] & upstream_valid[l];

    always_ff @(posedge clk) begin
      if (rst) begin
        found_q <= '0;
        idx_q   <= '0;
        tag_q   <= '0;
`ifdef HBS_LOW_BIT_EN
        mode_q  <= HBS_MODE_HIGH;
`endif
      end else if (load_data) begin
        found_q <= found_d;
        idx_q   <= idx_d;
        tag_q   <= child_tag;
`ifdef HBS_LOW_BIT_EN
        mode_q  <= child_mode;
`endif
      end
    end
  end

  assign out_valid = stage_valid_q[LEVELS-1];
  assign out_found = g_level[LEVELS-1].found_q;
  assign out_index = g_level[LEVELS-1].idx_q;
  assign out_tag   = g_level[LEVELS-1].tag_q;

endmodule

// File: tb/tb_high_bit_search_pipe.sv
// Self-checking bench for high_bit_search_pipe: 8-bit and 12-bit instances, scoreboard
// against a bit-scan reference. Define HBS_LOW_BIT_EN to also exercise low-bit mode.
module tb_high_bit_search_pipe;

  localparam int unsigned W   = 8;
  localparam int unsigned W12 = 12;

  typedef struct {
    logic [3:0] idx;
    logic       found;
    logic [3:0] tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready, in_mode;
  logic [7:0] in_data;
  logic [3:0] in_tag;
  logic       out_valid, out_ready, out_found;
  logic [2:0] out_index;
  logic [3:0] out_tag;

  logic        w12_in_valid, w12_in_ready, w12_in_mode, w12_out_ready;
  logic [11:0] w12_in_data;
  logic [3:0]  w12_in_tag;
  logic        w12_out_valid, w12_out_found;
  logic [3:0]  w12_out_index;
  logic [3:0]  w12_out_tag;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out, n_acc, first_acc, first_out, last_out;
  int w12_first_acc, w12_first_out;
  bit rand_ready;

  exp_t exp_q[$];
  exp_t exp12_q[$];

  logic [7:0] t1_words [10] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hCA,
                                8'hFE, 8'hBA, 8'hBA, 8'hDE, 8'hDA};
  logic [7:0] t2_words [4]  = '{8'h01, 8'h00, 8'h80, 8'h10};

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  high_bit_search_pipe #(
    .INPUT_WIDTH(W),
    .TAG_WIDTH  (4)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_tag   (in_tag),
`ifdef HBS_LOW_BIT_EN
    .in_mode  (in_mode),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_found(out_found),
    .out_tag  (out_tag)
  );

  high_bit_search_pipe #(
    .INPUT_WIDTH(W12),
    .TAG_WIDTH  (4)
  ) u_dut_w12 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (w12_in_valid),
    .in_ready (w12_in_ready),
    .in_data  (w12_in_data),
    .in_tag   (w12_in_tag),
`ifdef HBS_LOW_BIT_EN
    .in_mode  (w12_in_mode),
`endif
    .out_valid(w12_out_valid),
    .out_ready(w12_out_ready),
    .out_index(w12_out_index),
    .out_found(w12_out_found),
    .out_tag  (w12_out_tag)
  );

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: scan the word bit by bit; high mode keeps the last set bit, low mode the first.
  function automatic exp_t ref_search(input logic [15:0] data, input int width,
                                      input logic low_mode, input logic [3:0] tag);
    exp_t r;
    int   pos;
    bit   seen;
    pos  = 0;
    seen = 0;
    for (int i = 0; i < width; i++) begin
      if (data[i]) begin
        if (!seen || !low_mode) pos = i;
        seen = 1;
      end
    end
    r.idx   = 4'(pos);
    r.found = seen;
    r.tag   = tag;
    return r;
  endfunction

  // Handshakes are judged at the falling edge; the transfer happens on the next rising edge.
  always @(negedge clk) begin : p_mon
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check_val("out_has_input", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_val("out_index", 32'(out_index), 32'(e.idx));
          check_val("out_found", 32'(out_found), 32'(e.found));
          check_val("out_tag", 32'(out_tag), 32'(e.tag));
        end
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_search(16'(in_data), W, in_mode, in_tag));
        n_acc++;
        if (first_acc < 0) first_acc = cyc;
      end
    end
  end

  always @(negedge clk) begin : p_mon_w12
    exp_t e;
    if (rst) begin
      exp12_q.delete();
    end else begin
      if (w12_out_valid && w12_out_ready) begin
        check_val("w12_out_has_input", 32'(exp12_q.size() != 0), 32'd1);
        if (exp12_q.size() != 0) begin
          e = exp12_q.pop_front();
          check_val("w12_out_index", 32'(w12_out_index), 32'(e.idx));
          check_val("w12_out_found", 32'(w12_out_found), 32'(e.found));
          check_val("w12_out_tag", 32'(w12_out_tag), 32'(e.tag));
        end
        if (w12_first_out < 0) w12_first_out = cyc;
      end
      if (w12_in_valid && w12_in_ready) begin
        exp12_q.push_back(ref_search(16'(w12_in_data), W12, w12_in_mode, w12_in_tag));
        if (w12_first_acc < 0) w12_first_acc = cyc;
      end
    end
  end

  task automatic clear_stats();
    n_out         = 0;
    n_acc         = 0;
    first_acc     = -1;
    first_out     = -1;
    last_out      = -1;
    w12_first_acc = -1;
    w12_first_out = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [3:0] t, input logic m);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_tag   = t;
    in_mode  = m;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    check_val("send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send12(input logic [11:0] d, input logic [3:0] t);
    bit acc;
    acc          = 0;
    w12_in_valid = 1'b1;
    w12_in_data  = d;
    w12_in_tag   = t;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = w12_in_ready;
      tick();
    end
    w12_in_valid = 1'b0;
    check_val("w12_send_accepted", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || exp12_q.size() != 0); i++) tick();
    check_val("drain_main", 32'(exp_q.size()), 32'd0);
    check_val("drain_w12", 32'(exp12_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int            acc_cnt;
    bit            a;
    logic [2:0]    hold_idx;
    logic          hold_found;
    logic [3:0]    hold_tag;
    logic          m;

    rst           = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    in_tag        = '0;
    in_mode       = 1'b0;
    out_ready     = 1'b0;
    rand_ready    = 0;
    w12_in_valid  = 1'b0;
    w12_in_data   = '0;
    w12_in_tag    = '0;
    w12_in_mode   = 1'b0;
    w12_out_ready = 1'b1;
    clear_stats();
    repeat (3) tick();
    rst = 1'b0;

    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_index", 32'(out_index), 32'd0);
    check_val("rst_out_found", 32'(out_found), 32'd0);
    check_val("rst_out_tag", 32'(out_tag), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_w12_out_valid", 32'(w12_out_valid), 32'd0);

    // Streaming: latency of 3 (as seen at falling edges) and no gaps between results.
    out_ready = 1'b1;
    clear_stats();
    for (int i = 0; i < 10; i++) send(t1_words[i], 4'(i), 1'b0);
    drain();
    check_val("t1_count", 32'(n_out), 32'd10);
    check_val("t1_latency", 32'(first_out - first_acc), 32'd3);
    check_val("t1_no_gaps", 32'(last_out - first_out), 32'd9);

    clear_stats();
    for (int i = 0; i < 4; i++) send(t2_words[i], 4'(i), 1'b0);
    drain();
    check_val("t2_count", 32'(n_out), 32'd4);

    // Backpressure: a stalled consumer fills all 3 stages, then in_ready drops.
    clear_stats();
    out_ready = 1'b0;
    acc_cnt   = 0;
    in_valid  = 1'b1;
    in_data   = 8'($urandom);
    in_tag    = 4'd8;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      a = in_ready;
      if (c == 3) begin
        hold_idx   = out_index;
        hold_found = out_found;
        hold_tag   = out_tag;
      end else if (c > 3) begin
        check_val("bp_valid_held", 32'(out_valid), 32'd1);
        check_val("bp_index_stable", 32'(out_index), 32'(hold_idx));
        check_val("bp_found_stable", 32'(out_found), 32'(hold_found));
        check_val("bp_tag_stable", 32'(out_tag), 32'(hold_tag));
      end
      tick();
      if (a) begin
        acc_cnt++;
        in_data = 8'($urandom) >> $urandom_range(0, 7);
        in_tag  = 4'(in_tag + 1);
      end
    end
    @(negedge clk);
    check_val("bp_accepted", 32'(acc_cnt), 32'd3);
    check_val("bp_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(8'($urandom), 4'(i), 1'b0);
    drain();
    check_val("bp_out_count", 32'(n_out), 32'd8);

    // Mid-stream reset drops the three words in flight.
    for (int i = 0; i < 3; i++) send(8'h40 >> i, 4'(i + 1), 1'b0);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    out_ready = 1'b0;
    check_val("r4_out_valid", 32'(out_valid), 32'd0);
    check_val("r4_out_index", 32'(out_index), 32'd0);
    check_val("r4_out_found", 32'(out_found), 32'd0);
    check_val("r4_out_tag", 32'(out_tag), 32'd0);
    check_val("r4_in_ready", 32'(in_ready), 32'd1);
    clear_stats();
    out_ready = 1'b1;
    send(8'h24, 4'hC, 1'b0);
    drain();
    check_val("r4_count", 32'(n_out), 32'd1);
    check_val("r4_latency", 32'(first_out - first_acc), 32'd3);

`ifdef HBS_LOW_BIT_EN
    clear_stats();
    send(8'h58, 4'd1, 1'b1);
    send(8'h58, 4'd2, 1'b0);
    drain();
    check_val("mode_count", 32'(n_out), 32'd2);
    check_val("mode_no_gap", 32'(last_out - first_out), 32'd1);
`endif

    // Randomized traffic with a randomly stalling consumer.
    clear_stats();
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
`ifdef HBS_LOW_BIT_EN
      m = 1'($urandom);
`else
      m = 1'b0;
`endif
      send(8'($urandom) >> $urandom_range(0, 8), 4'($urandom), m);
      if ($urandom_range(0, 4) == 0) tick();
    end
    rand_ready = 0;
    drain();
    check_val("rand_count", 32'(n_out), 32'(n_acc));

    // 12-bit word padded to 16: four stages.
    clear_stats();
    send12(12'h800, 4'd1);
    send12(12'h001, 4'd2);
    send12(12'h000, 4'd3);
    for (int i = 0; i < 30; i++) send12(12'($urandom) >> $urandom_range(0, 12), 4'(i));
    drain();
    check_val("w12_latency", 32'(w12_first_out - w12_first_acc), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/high_bit_search_pipe.md
Name: high_bit_search_pipe

Overview:
Streaming, parametrised successor to the combinational high-bit search. Accepts INPUT_WIDTH-bit words over a valid/ready handshake and returns the index of the most significant set bit, plus a found flag and a sideband tag. Uses a log2-depth merge tree with one register per tree level, so full throughput is one word per clock with backpressure. Sits between a data producer and any consumer that needs priority-encoded results, such as normalisers or arbiters.

Parameters:
INPUT_WIDTH, 8, data word width; minimum 2, any value allowed; internally zero-padded at the MSB end to PAD_WIDTH = 2**IDX_WIDTH.
TAG_WIDTH, 4, sideband tag carried alongside each word; minimum 1.
IDX_WIDTH, $clog2(INPUT_WIDTH), derived localparam; also equals the tree depth LEVELS.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input word valid.
in_ready  out  1  block can accept an input word this cycle.
in_data  in  INPUT_WIDTH  word to search.
in_tag  in  TAG_WIDTH  sideband, returned unchanged with the result.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_index  out  IDX_WIDTH  bit position of the highest set bit.
out_found  out  1  1 if in_data was non-zero.
out_tag  out  TAG_WIDTH  tag of this result.

Behaviour:
- Transfer occurs on a rising clk edge where valid and ready are both high. Input and output follow the same rule.
- Tree: level 0 treats each bit as a leaf (found = bit, zero-width idx). Each level merges adjacent pairs (lo, hi):
  - found = hi.f | lo.f
  - idx = hi.f ? {1'b1, hi.idx} : {1'b0, lo.idx}
- There is one register stage after each level, LEVELS stages total. Each stage holds a valid bit, its partial node vector and the tag.
- Latency: a word accepted at edge N produces out_valid=1 after edge N+LEVELS, assuming no stall. For INPUT_WIDTH=8 the latency is 3 cycles.
- Bubble-collapsing flow control:
  - The last stage advances when out_ready is high or the stage is empty.
  - Stage k loads when it is empty or stage k+1 loads this cycle.
  - in_ready equals the load condition of stage 0 and is combinational from out_ready through the chain.
  - A stage that is not loading holds its contents unchanged.
- Output timing: out_* are driven directly from the last stage registers, with no combinational path from in_* to out_*. Output data stays stable while out_valid=1 and out_ready=0.
- Zero word: out_found=0 and out_index=0. Padding bits never report as found.
- Simultaneous accept and emit in one cycle is permitted. Sustained throughput is 1 word/cycle when out_ready is held high.
- Reset: all stage valid bits, out_valid, out_found, out_index and out_tag clear to 0. in_ready is 1 during the first cycle after reset is released. Reset mid-stream drops every in-flight word, and no partial results are emitted.
- Degenerate case: INPUT_WIDTH=2 gives a single stage and latency 1.

Optional Feature:
- Macro: HBS_LOW_BIT_EN.
- When defined:
  - Adds input port in_mode (1 bit), sampled with in_data and carried through the pipeline.
  - in_mode=1 selects lowest-set-bit search, with merge rule idx = lo.f ? {1'b0, lo.idx} : {1'b1, hi.idx}.
  - in_mode=0 gives the high-bit behaviour.
  - Mode may change per word with no bubble.
- When undefined: the port and the mode register are absent, and the block performs high-bit search only.

Decomposition:
- Package hbs_pkg holds:
  - the clog2 helper function;
  - the node struct {found, idx} sized per level via a parametrised width function;
  - the mode encoding constants HBS_MODE_HIGH=0 and HBS_MODE_LOW=1.
- One sub-module, hbs_merge_node: combinational merge of two child nodes, parametrised by child idx width, with an optional mode input. It is instantiated in a generate loop, PAD_WIDTH-1 nodes total.

Test Plan:
1. W=8, out_ready=1. Stream DE,AD,BE,EF,CA,FE,BA,BA,DE,DA back-to-back with tags 0..9. Expect 10 results, all index 7 and found=1, tags in order, first out_valid 3 cycles after the first accept, no gaps.
2. W=8. Send 01, 00, 80, 10. Expect (index 0, found 1), (index 0, found 0), (index 7, found 1), (index 4, found 1).
3. Backpressure:
   - Hold out_ready=0 for 6 cycles while in_valid=1. Expect exactly 3 words accepted, then in_ready=0, with the outputs stable.
   - Release out_ready. Expect results in order, nothing lost or duplicated.
4. Reset mid-stream: assert rst for 1 cycle with 3 words in flight. Next cycle expect out_valid=0 and all outputs 0. The next word sent returns correctly after 3 cycles.
5. W=12, padded to 16 with 4 stages. Input 800 gives index 11. Input 001 gives index 0. Input 000 gives found=0.
6. With HBS_LOW_BIT_EN, W=8. Send 58 with mode=1 (expect index 3), then 58 with mode=0 (expect index 6), back-to-back in consecutive cycles.
